// File: rtl/adder_tree_seq_pkg.sv
// Shared types and cycle-count helpers for the time-multiplexed
// adder-tree reduction sequencer.
package adder_tree_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int steps_in_pass(
    input int n,
    input int l,
    input int p
  );
    int c;
    c = n >> p;
    return (c >= 2 * l) ? c / (2 * l) : 1;
  endfunction

  function automatic int reduce_cycles(
    input int n,
    input int l
  );
    int t;
    t = 0;
    for (int p = 0; (n >> p) > 1; p++)
      t += steps_in_pass(n, l, p);
    return t;
  endfunction

  // Reduce cycles already spent before (pass, step) starts.
  function automatic int elapsed_cycles(
    input int n,
    input int l,
    input int pass,
    input int step
  );
    int t;
    t = 0;
    for (int p = 0; p < pass; p++)
      t += steps_in_pass(n, l, p);
    return t + step;
  endfunction

endpackage

// File: rtl/adder_tree_layer.sv
// One combinational layer of pairwise adders: out[i] = in[2i] + in[2i+1],
// wrapping at DATAW bits.
module adder_tree_layer #(
  parameter int INPUTS_AMOUNT = 2,
  parameter int DATAW         = 8
) (
  input  logic [INPUTS_AMOUNT-1:0][DATAW-1:0]   in_data_i,
  output logic [INPUTS_AMOUNT/2-1:0][DATAW-1:0] sum_o
);

  for (genvar i = 0; i < INPUTS_AMOUNT / 2; i++) begin : g_lane
    assign sum_o[i] = in_data_i[2*i] + in_data_i[2*i+1];
  end

endmodule

// File: rtl/adder_tree_sequencer.sv
// Sums NUM_INPUTS signed samples by folding a local buffer in place
// through one shared adder layer of 2*LANES inputs.
module adder_tree_sequencer
  import adder_tree_seq_pkg::*;
#(
  parameter  int NUM_INPUTS = 16,
  parameter  int DATAW      = 8,
  parameter  int LANES      = 4,
  localparam int SUMW       = DATAW + $clog2(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0]     in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [SUMW-1:0]               out_sum,
  output logic                                 busy
);

  localparam int PASSES = $clog2(NUM_INPUTS);
  localparam int TW     = 2 * LANES;
  localparam int LOG_L  = $clog2(LANES);
  localparam int LOG_TW = LOG_L + 1;
  localparam int IW     = $clog2(NUM_INPUTS);
  localparam int SW     = $clog2(NUM_INPUTS);
  localparam int PW     = $clog2(PASSES + 1);

  localparam logic [IW:0]   TW_C   = (IW+1)'(TW);
  localparam logic [IW:0]   N_C    = (IW+1)'(NUM_INPUTS);
  localparam logic [PW-1:0] LAST_P = PW'(PASSES - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic [SW-1:0]   step_q, step_d;
  logic [SUMW-1:0] mem_q [NUM_INPUTS];
  logic [SUMW-1:0] mem_d [NUM_INPUTS];

  logic [TW-1:0][SUMW-1:0]    lyr_in;
  logic [LANES-1:0][SUMW-1:0] lyr_out;

  logic [IW:0]   act_cnt;
  logic [IW:0]   rd_base;
  logic [IW:0]   wr_base;
  logic [SW-1:0] last_idx;
  logic          last_step;
  logic          last_pass;

  assign act_cnt = N_C >> pass_q;
  assign rd_base = (IW+1)'(step_q) << LOG_TW;
  assign wr_base = (IW+1)'(step_q) << LOG_L;

  always_comb begin
    last_idx = '0;
    if (act_cnt >= TW_C)
      last_idx = SW'((act_cnt >> LOG_TW) - 1'b1);
  end

  assign last_step = (step_q == last_idx);
  assign last_pass = (pass_q == LAST_P);

  // Entries at or beyond the active count feed zero to unused lanes.
  always_comb begin
    lyr_in = '0;
    for (int i = 0; i < TW; i++) begin
      if ((IW+1)'(i) < act_cnt)
        lyr_in[i] = mem_q[IW'(rd_base + (IW+1)'(i))];
    end
  end

  adder_tree_layer #(
    .INPUTS_AMOUNT (TW),
    .DATAW         (SUMW)
  ) u_layer (
    .in_data_i (lyr_in),
    .sum_o     (lyr_out)
  );

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    step_d  = step_q;
    mem_d   = mem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_INPUTS; k++)
              mem_d[k] = {{(SUMW-DATAW){in_data[k][DATAW-1]}},
                          in_data[k]};
            pass_d  = '0;
            step_d  = '0;
            state_d = REDUCE;
          end
        end
        REDUCE: begin
          for (int l = 0; l < LANES; l++) begin
            if ((IW+1)'(2 * l) < act_cnt)
              mem_d[IW'(wr_base + (IW+1)'(l))] = lyr_out[l];
          end
          if (last_step) begin
            step_d = '0;
            if (last_pass)
              state_d = DONE;
            else
              pass_d = pass_q + 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      step_q  <= '0;
      for (int k = 0; k < NUM_INPUTS; k++)
        mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      step_q  <= step_d;
      mem_q   <= mem_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = mem_q[0];

  always_ff @(posedge clk) begin
    if (!rst && !flush && state_q == REDUCE
        && last_step && last_pass)
      assert (elapsed_cycles(NUM_INPUTS, LANES,
                             int'(pass_q), int'(step_q)) + 1
              == reduce_cycles(NUM_INPUTS, LANES));
  end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench: default 16x4 instance plus an 8x1 instance
// for the partial-lane and single-lane step counts.
module tb_adder_tree_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic             a_flush, a_in_valid, a_out_ready;
  logic [15:0][7:0] a_in_data;
  logic             a_in_ready, a_out_valid, a_busy;
  logic [11:0]      a_out_sum;

  logic             b_flush, b_in_valid, b_out_ready;
  logic [7:0][7:0]  b_in_data;
  logic             b_in_ready, b_out_valid, b_busy;
  logic [10:0]      b_out_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int a_xfers = 0;

  adder_tree_sequencer u_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .busy      (a_busy)
  );

  adder_tree_sequencer #(
    .NUM_INPUTS (8),
    .DATAW      (8),
    .LANES      (1)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .busy      (b_busy)
  );

  always @(posedge clk)
    if (a_out_valid && a_out_ready) a_xfers++;

  task automatic a_send(input logic [15:0][7:0] v);
    a_in_data  = v;
    a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait(output int n);
    n = 0;
    while (!a_out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic a_fill(input logic [7:0] x,
                        output logic [15:0][7:0] v);
    for (int k = 0; k < 16; k++) v[k] = x;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    end
    n_cmp++;
    if (a_out_sum !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_out_sum: got %h want 000", a_out_sum);
    end
    n_cmp++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b/%b want 0/0", a_busy, b_busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones;
    logic [15:0][7:0] v;
    int n, x0;
    a_fill(8'd1, v);
    a_out_ready = 1'b1;
    x0 = a_xfers;
    a_send(v);
    n_cmp++;
    if (a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ones_busy: got rdy=%b busy=%b want 0/1",
               a_in_ready, a_busy);
    end
    a_wait(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL ones_latency: got %0d want 5", n);
    end
    n_cmp++;
    if (a_out_sum !== 12'd16) begin
      n_bad++;
      $display("FAIL ones_sum: got %0d want 16", $signed(a_out_sum));
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ones_after: got rdy=%b vld=%b want 1/0",
               a_in_ready, a_out_valid);
    end
    n_cmp++;
    if (a_xfers - x0 !== 1) begin
      n_bad++;
      $display("FAIL ones_xfers: got %0d want 1", a_xfers - x0);
    end
  endtask

  task automatic test_extremes;
    logic [15:0][7:0] v;
    int n;
    a_out_ready = 1'b1;
    a_fill(8'h80, v);
    a_send(v);
    a_wait(n);
    n_cmp++;
    if (a_out_sum !== 12'h800) begin
      n_bad++;
      $display("FAIL min_sum: got %h want 800", a_out_sum);
    end
    @(posedge clk);
    @(negedge clk);
    a_fill(8'h7F, v);
    a_send(v);
    a_wait(n);
    n_cmp++;
    if (a_out_sum !== 12'h7F0) begin
      n_bad++;
      $display("FAIL max_sum: got %0d want 2032", $signed(a_out_sum));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0][7:0] v, w, r;
    int n;
    for (int k = 0; k < 16; k++) begin
      v[k] = (k % 2 == 0) ? 8'd5 : 8'hFD;
      r[k] = 8'(k);
    end
    a_fill(8'd7, w);
    a_out_ready = 1'b1;
    a_send(v);
    a_in_data  = w;
    a_in_valid = 1'b1;
    a_wait(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL b2b_first_latency: got %0d want 5", n);
    end
    n_cmp++;
    if (a_out_sum !== 12'd16) begin
      n_bad++;
      $display("FAIL b2b_first_sum: got %0d want 16",
               $signed(a_out_sum));
    end
    a_in_data = r;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %b want 1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_wait(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL b2b_second_latency: got %0d want 5", n);
    end
    n_cmp++;
    if (a_out_sum !== 12'd120) begin
      n_bad++;
      $display("FAIL b2b_second_sum: got %0d want 120",
               $signed(a_out_sum));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [15:0][7:0] v;
    int n, x0;
    a_fill(8'd1, v);
    a_out_ready = 1'b0;
    a_send(v);
    a_wait(n);
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want 5", n);
    end
    x0 = a_xfers;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_sum !== 12'd16
          || a_in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got vld=%b sum=%0d rdy=%b want 1/16/0",
                 i, a_out_valid, $signed(a_out_sum), a_in_ready);
      end
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    n_cmp++;
    if (a_xfers - x0 !== 1) begin
      n_bad++;
      $display("FAIL bp_xfers: got %0d want 1", a_xfers - x0);
    end
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_after: got vld=%b rdy=%b want 0/1",
               a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0][7:0] v;
    a_fill(8'd1, v);
    a_out_ready = 1'b1;
    a_send(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_busy: got %b want 1", a_busy);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0
        || a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_ctrl: got rdy=%b vld=%b busy=%b want 1/0/0",
               a_in_ready, a_out_valid, a_busy);
    end
    n_cmp++;
    if (a_out_sum !== 12'h000) begin
      n_bad++;
      $display("FAIL rstmid_sum: got %h want 000", a_out_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_done;
    logic [15:0][7:0] v;
    int n, x0;
    a_fill(8'd1, v);
    a_out_ready = 1'b0;
    a_send(v);
    a_wait(n);
    x0 = a_xfers;
    a_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_flush = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_ctrl: got vld=%b rdy=%b want 0/1",
               a_out_valid, a_in_ready);
    end
    n_cmp++;
    if (a_xfers !== x0) begin
      n_bad++;
      $display("FAIL flush_xfers: got %0d want %0d", a_xfers, x0);
    end
    n_cmp++;
    if (a_out_sum !== 12'd16) begin
      n_bad++;
      $display("FAIL flush_buf_kept: got %0d want 16",
               $signed(a_out_sum));
    end
  endtask

  task automatic test_small;
    int n;
    for (int k = 0; k < 8; k++) b_in_data[k] = 8'(-(k + 1));
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 7) begin
      n_bad++;
      $display("FAIL small_latency: got %0d want 7", n);
    end
    n_cmp++;
    if (b_out_sum !== 11'h7DC) begin
      n_bad++;
      $display("FAIL small_sum: got %0d want -36", $signed(b_out_sum));
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL small_after: got rdy=%b vld=%b want 1/0",
               b_in_ready, b_out_valid);
    end
  endtask

  initial begin
    rst         = 1'b1;
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_in_data   = '0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_in_data   = '0;
    test_reset;
    test_ones;
    test_extremes;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_flush_done;
    test_small;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
